sumador_serial: RTL and testbench

Bit-serial 5-bit adder, the inverse of the 5-bit two's-complement subtractor: given a difference and the subtrahend it reconstructs the minuend (`a + b`). It uses one full-adder cell plus a carry flip-flop and processes one bit per clock, LSB first. It sits beside the subtractor in the arithmetic datapath and trades latency for area. It uses a start/done handshake with a busy flag.

---
 rtl/sumador_serial.sv | 95 +++++++++
 tb/tb_sumador_serial.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sumador_serial.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flip-flop, LSB first.
// Reconstructs the minuend from a difference and its subtrahend with a start/done handshake.
module sumador_serial #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] suma,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             cy;
  logic [CW-1:0]    cnt;

  // The single full-adder cell, fed from the LSBs of the operand shifters.
  logic s;
  logic cy_next;

  assign s       = sa[0] ^ sb[0] ^ cy;
  assign cy_next = (sa[0] & sb[0]) | (sa[0] & cy) | (sb[0] & cy);

  // NOTE: every register, including the shifters, is cleared by the async reset
  // so an aborted operation leaves nothing behind; all updates are non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      suma  <= '0;
      c_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            cy    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          // start is deliberately not looked at here.
          cy  <= cy_next;
          sr  <= {s, sr[WIDTH-1:1]};
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            suma  <= {s, sr[WIDTH-1:1]};
            c_out <= cy_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serial.sv
// Directed and swept check of sumador_serial against a queue of expected {c_out, suma}.
module tb_sumador_serial;

  localparam int W = 5;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] suma;
  logic         c_out;

  int total = 0;
  int bad   = 0;

  logic [W:0] sb_q[$];
  logic       done_q = 1'b0;

  sumador_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .suma  (suma),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Protocol invariants sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("busy_done_excl", {31'b0, busy & done}, 32'd0);
    if (done_q) check("done_width", {31'b0, done}, 32'd0);
    done_q = done;
  end

  // Called just after an active edge; returns edges counted until done is seen.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic compare_result(input string tag);
    logic [W:0] exp;
    exp = sb_q.pop_front();
    check(tag, {26'b0, c_out, suma}, {26'b0, exp});
  endtask

  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input string tag);
    int cyc;
    @(negedge clk);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    sb_q.push_back({1'b0, op_a} + {1'b0, op_b});
    @(posedge clk);
    #1;
    check({tag, "_busy_rise"}, {31'b0, busy}, 32'd1);
    start = 1'b0;
    wait_done(cyc);
    check({tag, "_latency"}, cyc, W);
    check({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
    compare_result({tag, "_result"});
  endtask

  initial begin
    int  cyc;
    int  r;
    bit  saw_done;
    logic [9:0] idx;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_suma", {27'b0, suma}, 32'd0);
    check("rst_cout", {31'b0, c_out}, 32'd0);
    rst_n = 1'b1;

    do_op(5'd13, 5'd9, "op_13_9");
    do_op(5'd7, 5'd3, "inv_7_3");
    do_op(5'd31, 5'd1, "wrap_31_1");

    // Back-to-back with start held high.
    @(negedge clk);
    a     = 5'd5;
    b     = 5'd6;
    start = 1'b1;
    sb_q.push_back(6'd11);
    @(posedge clk);
    #1;
    check("b2b_busy0", {31'b0, busy}, 32'd1);
    @(negedge clk);
    a = 5'd20;
    b = 5'd20;
    sb_q.push_back(6'd40);
    wait_done(cyc);
    check("b2b_lat0", cyc, W);
    compare_result("b2b_res0");
    @(posedge clk);
    #1;
    check("b2b_done_fall", {31'b0, done}, 32'd0);
    check("b2b_busy_rise", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("b2b_period", cyc + 1, W + 1);
    compare_result("b2b_res1");

    // start re-pulsed mid-RUN is ignored; suma keeps 8 until the new done.
    @(negedge clk);
    a     = 5'd3;
    b     = 5'd4;
    start = 1'b1;
    sb_q.push_back(6'd7);
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a     = 5'd31;
    b     = 5'd31;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("mid_suma_hold", {27'b0, suma}, 32'd8);
    check("mid_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    wait_done(cyc);
    check("mid_latency", cyc, W - 2);
    compare_result("mid_result");

    // Reset during the third RUN cycle aborts the operation.
    @(negedge clk);
    a     = 5'd13;
    b     = 5'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_suma", {27'b0, suma}, 32'd0);
    check("abort_cout", {31'b0, c_out}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'b0, saw_done}, 32'd0);
    do_op(5'd0, 5'd0, "post_abort_0_0");

    // Every operand pair, visited in a scrambled order.
    r = int'($urandom_range(0, 1023));
    for (int i = 0; i < 1024; i++) begin
      idx = 10'((i * 613 + r) % 1024);
      do_op(idx[9:5], idx[4:0], "sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
